// File: rtl/stream_in_arbiter_if.sv
// Requester-side and datapath-side stream handshake shared by the arbiter.
// The arbiter uses the slave modport. Requester models and the datapath use the master modport.
interface stream_in_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          stream_in_valid;
    logic [DATA_WIDTH-1:0]         stream_in_data;
    logic                          stream_in_ready;

    modport master (
        output req_valid, req_data, req_last, stream_in_ready,
        input  req_ready, stream_in_valid, stream_in_data
    );

    modport slave (
        input  req_valid, req_data, req_last, stream_in_ready,
        output req_ready, stream_in_valid, stream_in_data
    );
endinterface

// File: rtl/stream_in_arbiter.sv
// Round-robin burst arbiter: one requester at a time drives stream_in_*.
// A grant lasts until that requester's last beat or MAX_BURST beats, whichever comes first.
module stream_in_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    stream_in_arbiter_if.slave     bus,
    output logic                   grant_active,
    output logic [ID_W-1:0]        grant_id,
    output logic [7:0]             beat_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;

    logic [ID_W-1:0]       pick_id;
    logic                  pick_found;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  s_valid;
    logic                  beat;
    logic                  burst_done;
    logic                  release_now;
    logic [ID_W-1:0]       next_ptr;

    // Search starts at rr_ptr and wraps, so the most recently served index goes last.
    always_comb begin : rr_select
        int idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx        = 0;
        pick_id    = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_found && bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin : grant_mux
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                g_valid = bus.req_valid[k];
                g_last  = bus.req_last[k];
                g_data  = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin : ready_route
        bus.req_ready = '0;
        if (state == GRANT) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant_id == ID_W'(k)) begin
                    bus.req_ready[k] = bus.stream_in_ready;
                end
            end
        end
    end

    assign s_valid             = (state == GRANT) && g_valid;
    assign bus.stream_in_valid = s_valid;
    assign bus.stream_in_data  = s_valid ? g_data : '0;

    assign beat        = s_valid && bus.stream_in_ready;
    assign burst_done  = ({1'b0, beat_count} + 9'd1) == 9'(MAX_BURST);
    assign release_now = beat && (g_last || burst_done);
    assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            beat_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state        <= GRANT;
                        grant_active <= 1'b1;
                        grant_id     <= pick_id;
                        beat_count   <= '0;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        beat_count <= beat_count + 8'd1;
                        if (release_now) begin
                            state        <= IDLE;
                            grant_active <= 1'b0;
                            rr_ptr       <= next_ptr;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_ready));
    a_active_tracks_state: assert property (@(posedge clk) grant_active == (state == GRANT));
    a_burst_bounded: assert property (@(posedge clk) disable iff (reset) 9'(beat_count) <= 9'(MAX_BURST));

endmodule

// File: tb/tb_stream_in_arbiter.sv
// Self-checking bench for stream_in_arbiter: per-cycle vector table plus
// queue-driven requester models checked against an expected-beat scoreboard.
module tb_stream_in_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stream_in_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
    logic       ga;
    logic [1:0] gid;
    logic [7:0] bc;

    stream_in_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_active(ga), .grant_id(gid), .beat_count(bc)
    );

    stream_in_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(DW)) bus1 ();
    logic       ga1;
    logic       gid1;
    logic [7:0] bc1;

    stream_in_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .grant_active(ga1), .grant_id(gid1), .beat_count(bc1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        sready;
        logic        e_ga;
        logic [1:0]  e_gid;
        logic        e_sv;
        logic [7:0]  e_sd;
        logic [3:0]  e_rr;
        logic [7:0]  e_bc;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    bfm_en   = 1'b0;
    bit    sb_en    = 1'b0;
    beat_t rq[NR][$];
    exp_t  sb_q[$];
    int    beat_cyc[$];
    vec_t  vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic r, input logic e_ga, input logic [1:0] e_gid,
                                input logic e_sv, input logic [7:0] e_sd, input logic [3:0] e_rr,
                                input logic [7:0] e_bc);
        vec_t t;
        t.valid = v;  t.last = l;  t.data = d;  t.sready = r;
        t.e_ga = e_ga;  t.e_gid = e_gid;  t.e_sv = e_sv;
        t.e_sd = e_sd;  t.e_rr = e_rr;  t.e_bc = e_bc;
        return t;
    endfunction

    task automatic drive_q();
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() > 0) begin
                bus.req_valid[k]           = 1'b1;
                bus.req_data[k*DW +: DW]   = rq[k][0].data;
                bus.req_last[k]            = rq[k][0].last;
            end else begin
                bus.req_valid[k]           = 1'b0;
                bus.req_data[k*DW +: DW]   = '0;
                bus.req_last[k]            = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        rq[k].push_back(b);
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One clock: observe the handshake on the falling edge, then advance the requester queues.
    task automatic step();
        logic [NR-1:0] fire;
        exp_t          e;
        @(negedge clk);
        cyc++;
        fire = bus.req_valid & bus.req_ready;
        if (sb_en && bus.stream_in_valid && bus.stream_in_ready) begin
            beat_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                fail_now("sb_unexpected_beat", $sformatf("data 0x%0h from id %0d", bus.stream_in_data, gid));
            end else begin
                e = sb_q.pop_front();
                check("sb_grant_id", 32'(gid), 32'(e.id));
                check("sb_data", 32'(bus.stream_in_data), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
        if (bfm_en) begin
            for (int k = 0; k < NR; k++) begin
                if (fire[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            drive_q();
        end
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (sb_q.size() > 0) fail_now(name, $sformatf("timeout with %0d beats outstanding", sb_q.size()));
    endtask

    task automatic clear_queues();
        for (int k = 0; k < NR; k++) rq[k].delete();
        drive_q();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        clear_queues();
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Rows: inputs {valid, last, data{d3,d2,d1,d0}, ready} | expected {ga, gid, sv, sd, req_ready, bc}
        vecs[0]  = mk(4'b0100, 4'b0000, 32'hCC11DDEE, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 8'd0);
        vecs[1]  = mk(4'b0100, 4'b0000, 32'hCC11DDEE, 1'b1, 1'b1, 2'd2, 1'b1, 8'h11, 4'b0100, 8'd0);
        vecs[2]  = mk(4'b0100, 4'b0000, 32'hCC22DDEE, 1'b1, 1'b1, 2'd2, 1'b1, 8'h22, 4'b0100, 8'd1);
        vecs[3]  = mk(4'b0100, 4'b0100, 32'hCC33DDEE, 1'b1, 1'b1, 2'd2, 1'b1, 8'h33, 4'b0100, 8'd2);
        vecs[4]  = mk(4'b1010, 4'b1010, 32'h553344EE, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000, 8'd3);
        vecs[5]  = mk(4'b1010, 4'b1010, 32'h553344EE, 1'b1, 1'b1, 2'd3, 1'b1, 8'h55, 4'b1000, 8'd0);
        vecs[6]  = mk(4'b0010, 4'b0010, 32'h553344EE, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'b0000, 8'd1);
        vecs[7]  = mk(4'b0010, 4'b0010, 32'h553344EE, 1'b1, 1'b1, 2'd1, 1'b1, 8'h44, 4'b0010, 8'd0);
        vecs[8]  = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 8'd1);
        vecs[9]  = mk(4'b0001, 4'b0001, 32'h000000A5, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 8'd1);
        vecs[10] = mk(4'b0001, 4'b0001, 32'h000000A5, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA5, 4'b0000, 8'd0);
        vecs[11] = mk(4'b0001, 4'b0001, 32'h000000A5, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA5, 4'b0000, 8'd0);
        vecs[12] = mk(4'b0001, 4'b0001, 32'h000000A5, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA5, 4'b0000, 8'd0);
        vecs[13] = mk(4'b0001, 4'b0001, 32'h000000A5, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA5, 4'b0001, 8'd0);
        vecs[14] = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 8'd1);
        vecs[15] = mk(4'b0010, 4'b0000, 32'h00007700, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 8'd1);
        vecs[16] = mk(4'b0000, 4'b0000, 32'h00007700, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 4'b0010, 8'd0);
        vecs[17] = mk(4'b0010, 4'b0010, 32'h00007800, 1'b1, 1'b1, 2'd1, 1'b1, 8'h78, 4'b0010, 8'd0);
        vecs[18] = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 8'd1);

        reset                = 1'b1;
        bus.req_valid        = '0;
        bus.req_data         = '0;
        bus.req_last         = '0;
        bus.stream_in_ready  = 1'b0;
        bus1.req_valid       = '0;
        bus1.req_data        = '0;
        bus1.req_last        = '0;
        bus1.stream_in_ready = 1'b0;

        // Reset held two cycles, then ten idle cycles with no requests.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_grant_active", 32'(ga), 32'd0);
            check("reset_beat_count", 32'(bc), 32'd0);
            check("reset_stream_valid", 32'(bus.stream_in_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_grant_active", 32'(ga), 32'd0);
            check("idle_req_ready", 32'(bus.req_ready), 32'd0);
            check("idle_stream_valid", 32'(bus.stream_in_valid), 32'd0);
            check("idle_grant_id", 32'(gid), 32'd0);
        end

        // Vector table: single burst, rr_ptr advance, backpressure, dropped valid.
        for (int i = 0; i < 19; i++) begin
            bus.req_valid       = vecs[i].valid;
            bus.req_last        = vecs[i].last;
            bus.req_data        = vecs[i].data;
            bus.stream_in_ready = vecs[i].sready;
            @(negedge clk);
            check($sformatf("vec%0d_grant_active", i), 32'(ga), 32'(vecs[i].e_ga));
            check($sformatf("vec%0d_grant_id", i), 32'(gid), 32'(vecs[i].e_gid));
            check($sformatf("vec%0d_stream_valid", i), 32'(bus.stream_in_valid), 32'(vecs[i].e_sv));
            check($sformatf("vec%0d_stream_data", i), 32'(bus.stream_in_data), 32'(vecs[i].e_sd));
            check($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rr));
            check($sformatf("vec%0d_beat_count", i), 32'(bc), 32'(vecs[i].e_bc));
            @(posedge clk);
            #1;
        end

        // Round robin: every requester always valid with single-beat bursts.
        bfm_en              = 1'b1;
        sb_en               = 1'b1;
        bus.stream_in_ready = 1'b1;
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NR; k++) begin
                push_beat(k, 8'(8'h10 * (r + 1) + k), 1'b1);
                expect_beat(2'(k), 8'(8'h10 * (r + 1) + k));
            end
        end
        drive_q();
        beat_cyc.delete();
        run_until_drained("rr_drain", 60);
        for (int i = 1; i < beat_cyc.size(); i++) begin
            check("rr_bubble_gap", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd2);
        end

        // Burst cap: requester 1 streams 6 beats without last while 2, 3, 0 queue up.
        for (int i = 0; i < 6; i++) push_beat(1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 4; i++) expect_beat(2'd1, 8'(8'hA0 + i));
        expect_beat(2'd2, 8'hB2);
        expect_beat(2'd3, 8'hB3);
        expect_beat(2'd0, 8'hB0);
        expect_beat(2'd1, 8'hA4);
        expect_beat(2'd1, 8'hA5);
        drive_q();
        step();
        push_beat(2, 8'hB2, 1'b1);
        push_beat(3, 8'hB3, 1'b1);
        push_beat(0, 8'hB0, 1'b1);
        drive_q();
        repeat (4) step();
        check("cap_grant_active", 32'(ga), 32'd0);
        check("cap_beat_count", 32'(bc), 32'd4);
        check("cap_grant_id", 32'(gid), 32'd1);
        run_until_drained("cap_drain", 60);
        repeat (2) step();
        check("hold_grant_active", 32'(ga), 32'd1);
        check("hold_grant_id", 32'(gid), 32'd1);
        check("hold_beat_count", 32'(bc), 32'd2);

        // Reset in the middle of a burst from requester 3.
        reset_dut();
        push_beat(2, 8'hE2, 1'b1);
        expect_beat(2'd2, 8'hE2);
        drive_q();
        run_until_drained("pre_reset_drain", 20);
        for (int i = 0; i < 4; i++) push_beat(3, 8'(8'hC0 + i), i == 3);
        expect_beat(2'd3, 8'hC0);
        drive_q();
        step();
        step();
        check("mid_grant_id", 32'(gid), 32'd3);
        check("mid_beat_count", 32'(bc), 32'd1);
        reset = 1'b1;
        sb_en = 1'b0;
        step();
        reset = 1'b0;
        sb_en = 1'b1;
        clear_queues();
        check("abort_grant_active", 32'(ga), 32'd0);
        check("abort_grant_id", 32'(gid), 32'd0);
        check("abort_beat_count", 32'(bc), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        push_beat(0, 8'hD0, 1'b1);
        push_beat(3, 8'hD3, 1'b1);
        expect_beat(2'd0, 8'hD0);
        expect_beat(2'd3, 8'hD3);
        drive_q();
        run_until_drained("post_reset_drain", 20);

        // Last flag coinciding with the burst cap advances rr_ptr once.
        for (int i = 0; i < 4; i++) begin
            push_beat(2, 8'(8'hF0 + i), i == 3);
            expect_beat(2'd2, 8'(8'hF0 + i));
        end
        expect_beat(2'd3, 8'h63);
        expect_beat(2'd0, 8'h60);
        drive_q();
        step();
        push_beat(3, 8'h63, 1'b1);
        push_beat(0, 8'h60, 1'b1);
        drive_q();
        repeat (4) step();
        check("both_grant_active", 32'(ga), 32'd0);
        check("both_beat_count", 32'(bc), 32'd4);
        run_until_drained("both_drain", 30);
        bfm_en = 1'b0;
        sb_en  = 1'b0;

        // MAX_BURST=1 instance: every beat releases, so grants alternate with bubbles.
        bus1.stream_in_ready = 1'b1;
        bus1.req_valid       = 2'b01;
        bus1.req_data        = 16'h005A;
        bus1.req_last        = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("mb1_grant_active", 32'(ga1), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("mb1_beat_count", 32'(bc1), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("mb1_grant_id", 32'(gid1), 32'd0);
            check("mb1_stream_data", 32'(bus1.stream_in_data), (i % 2 == 0) ? 32'h5A : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
